div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Sequential signed 32-bit divider feeding the HI/LO registers through the HI/LO source mux.
- Consumes the A and B register outputs (dividend, divisor) and a one-cycle start pulse from the control unit.
- Produces the quotient (LO), the remainder (HI), a divide-by-zero flag for the exception path, and a done pulse.
- Restoring algorithm: one quotient bit per cycle, with fixed latency independent of operand values.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a division; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (A register).
- divisor  input  WIDTH  signed divisor (B register).
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when hi/lo are updated.
- divzero  output  1  one-cycle pulse when start is seen with divisor == 0.
- hi  output  WIDTH  remainder of the last completed division.
- lo  output  WIDTH  quotient of the last completed division.

Behaviour:
- Reset, synchronous and active-high:
  - state <= IDLE.
  - busy, done, divzero <= 0.
  - hi, lo <= 0.
  - Internal counter and working registers cleared.
  - Reset overrides all other inputs, including mid-operation. An aborted division never asserts done.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1 with divisor != 0 at edge T:
    - Latch the sign of the quotient (dividend[W-1] ^ divisor[W-1]) and the sign of the remainder (dividend[W-1]).
    - Latch the magnitudes |dividend| and |divisor| as unsigned WIDTH-bit values. |0x80000000| is 0x80000000.
    - Clear the partial remainder (WIDTH+1 bits) and set count <= 0.
    - Go to CALC; busy=1 from T+1.
  - On start=1 with divisor == 0 at edge T:
    - divzero=1 for exactly cycle T+1.
    - Stay in IDLE; busy stays 0; done stays 0.
    - hi and lo hold their previous values.
- CALC, one iteration per cycle, WIDTH cycles:
  - Shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set quotient bit 0 to 1; otherwise restore and set it to 0.
  - count increments each cycle. After the iteration with count == WIDTH-1, go to FIX.
- FIX, 1 cycle:
  - lo <= quotient sign ? -q : q.
  - hi <= remainder sign ? -r : r.
  - Negation is two's complement, truncated to WIDTH bits.
  - Go to DONE.
- DONE, 1 cycle: done=1, busy=0; return to IDLE.
- Latency: start at edge T gives done high during cycle T+WIDTH+2 (T+34 for WIDTH=32).
  - New hi/lo are visible in that same cycle and held until the next completion or reset.
- busy is high from cycle T+1 through T+WIDTH+1 inclusive.
- Arithmetic semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend; |hi| < |divisor|.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps; no overflow flag).
- Operand capture: dividend and divisor are sampled only at the start edge. Later changes on the inputs during CALC have no effect.
- start while busy, or in FIX/DONE, is ignored and is not queued.
- start asserted in the same cycle as done (DONE state) is ignored. The control unit re-issues start from IDLE.
- Sign-magnitude conversion and the final negation are the only wide adders besides the trial subtractor.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- 7 / 2:
  - start at T → busy at T+1; done at T+34; lo=0x00000003, hi=0x00000001.
- -7 / 2 (0xFFFFFFF9 / 0x00000002):
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- 7 / -2:
  - lo=0xFFFFFFFD, hi=0x00000001.
- -7 / -2:
  - lo=0x00000003, hi=0xFFFFFFFF.
- 0x80000000 / 0xFFFFFFFF:
  - lo=0x80000000, hi=0x00000000, done at T+34.
- Divide by zero (100 / 0, with prior result hi=1, lo=3):
  - divzero=1 only at T+1; busy and done stay 0; hi=1, lo=3 unchanged.
  - A following 9 / 3 completes normally with lo=3, hi=0.
- Interference and abort:
  - Start 1000 / 7; pulse start with other operands at T+5 and change dividend/divisor at T+6 → ignored; result lo=142, hi=6 at T+34.
  - Separate run: assert reset at T+10 → next cycle busy=0, hi=lo=0, and done never pulses for the aborted run.

Source files
------------

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed restoring divider feeding HI/LO
// One quotient bit per cycle over magnitudes; signs are applied in a single fix-up cycle.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic             qsign;
  logic             rsign;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dsr_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

  // The remainder stays below the divisor magnitude, so one extra bit holds the shifted value.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      dsr     <= '0;
      qsign   <= 1'b0;
      rsign   <= 1'b0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              divzero <= 1'b1;
            end else begin
              qsign <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              rsign <= dividend[WIDTH-1];
              quo   <= dvd_mag;
              dsr   <= dsr_mag;
              rem   <= '0;
              count <= '0;
              busy  <= 1'b1;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          lo    <= qsign ? -quo : quo;
          hi    <= rsign ? -rem : rem;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - randomized and directed checks of div_seq against a signed-arithmetic model
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        divzero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .divzero(divzero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: C-style truncating division on 64-bit signed values, cut back to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    q = lq[31:0];
    r = lr[31:0];
  endfunction

  // Issues one start pulse and follows the run; returns at the cycle done is seen.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q_o, output logic [31:0] r_o,
                         output int done_at, output bit busy_ok);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    done_at  = -1;
    busy_ok  = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) tick();
      if (done) begin
        done_at = n;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    q_o = lo;
    r_o = hi;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) tick();
    reset = 1'b0;
    total += 5;
    if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    if (divzero !== 1'b0) begin bad++; $display("FAIL reset_divzero got=%b want=0", divzero); end
    if (hi !== 32'h0)     begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    if (lo !== 32'h0)     begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
  endtask

  task automatic test_directed;
    logic [31:0] va [5] = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] vb [5] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] eq [5] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3, 32'h80000000};
    logic [31:0] er [5] = '{32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0};
    logic [31:0] q, r;
    int d;
    bit bok;
    for (int i = 0; i < 5; i++) begin
      run_div(va[i], vb[i], q, r, d, bok);
      total += 4;
      if (d !== 34) begin bad++; $display("FAIL dir%0d_latency got=%0d want=34", i, d); end
      if (!bok)     begin bad++; $display("FAIL dir%0d_busy got=bad want=high_until_done", i); end
      if (q !== eq[i]) begin bad++; $display("FAIL dir%0d_lo got=%h want=%h", i, q, eq[i]); end
      if (r !== er[i]) begin bad++; $display("FAIL dir%0d_hi got=%h want=%h", i, r, er[i]); end
      tick();
    end
  endtask

  task automatic test_divzero;
    logic [31:0] q, r;
    int d;
    bit bok;
    bit seen_done;
    run_div(32'd7, 32'd2, q, r, d, bok);
    tick();
    dividend = 32'd100;
    divisor  = 32'd0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    total += 3;
    if (divzero !== 1'b1) begin bad++; $display("FAIL dz_pulse got=%b want=1", divzero); end
    if (busy !== 1'b0)    begin bad++; $display("FAIL dz_busy got=%b want=0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL dz_done got=%b want=0", done); end
    tick();
    total += 1;
    if (divzero !== 1'b0) begin bad++; $display("FAIL dz_width got=%b want=0", divzero); end
    seen_done = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (done || busy) seen_done = 1'b1;
      tick();
    end
    total += 3;
    if (seen_done) begin bad++; $display("FAIL dz_quiet got=activity want=idle"); end
    if (hi !== 32'd1) begin bad++; $display("FAIL dz_hold_hi got=%h want=1", hi); end
    if (lo !== 32'd3) begin bad++; $display("FAIL dz_hold_lo got=%h want=3", lo); end
    run_div(32'd9, 32'd3, q, r, d, bok);
    total += 3;
    if (d !== 34)     begin bad++; $display("FAIL dz_next_latency got=%0d want=34", d); end
    if (q !== 32'd3)  begin bad++; $display("FAIL dz_next_lo got=%h want=3", q); end
    if (r !== 32'd0)  begin bad++; $display("FAIL dz_next_hi got=%h want=0", r); end
    tick();
  endtask

  task automatic test_interference;
    int n;
    int d;
    dividend = 32'd1000;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    n = 1;
    while (n < 5) begin tick(); n++; end
    dividend = 32'd55;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    n++;
    start    = 1'b0;
    dividend = 32'hFFFFD8F1;
    divisor  = 32'd2;
    total += 1;
    if (busy !== 1'b1) begin bad++; $display("FAIL intf_busy got=%b want=1", busy); end
    d = -1;
    while (n <= 60) begin
      if (done) begin d = n; break; end
      tick();
      n++;
    end
    total += 3;
    if (d !== 34)      begin bad++; $display("FAIL intf_latency got=%0d want=34", d); end
    if (lo !== 32'd142) begin bad++; $display("FAIL intf_lo got=%0d want=142", lo); end
    if (hi !== 32'd6)   begin bad++; $display("FAIL intf_hi got=%0d want=6", hi); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] q, r, eq2, er2;
    int d;
    bit bok;
    run_div(32'd500, 32'd9, q, r, d, bok);
    dividend = 32'd77;
    divisor  = 32'd5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_ignored_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL b2b_ignored_done got=%b want=0", done); end
    model(32'hFFFFFF00, 32'd7, eq2, er2);
    run_div(32'hFFFFFF00, 32'd7, q, r, d, bok);
    total += 3;
    if (d !== 34)  begin bad++; $display("FAIL b2b_latency got=%0d want=34", d); end
    if (q !== eq2) begin bad++; $display("FAIL b2b_lo got=%h want=%h", q, eq2); end
    if (r !== er2) begin bad++; $display("FAIL b2b_hi got=%h want=%h", r, er2); end
    tick();
  endtask

  task automatic test_random;
    logic [31:0] a, b, q, r, eq, er;
    int d;
    bit bok;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(1, 20);
        1: b = -$urandom_range(1, 20);
        2: b = $urandom >> $urandom_range(0, 30);
        default: b = $urandom;
      endcase
      if (b == 32'd0) b = 32'd13;
      if (i == 0) a = 32'h80000000;
      model(a, b, eq, er);
      run_div(a, b, q, r, d, bok);
      total += 4;
      if (d !== 34) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=34", i, d); end
      if (!bok)     begin bad++; $display("FAIL rnd%0d_busy got=bad want=high_until_done", i); end
      if (q !== eq) begin bad++; $display("FAIL rnd%0d_lo a=%h b=%h got=%h want=%h", i, a, b, q, eq); end
      if (r !== er) begin bad++; $display("FAIL rnd%0d_hi a=%h b=%h got=%h want=%h", i, a, b, r, er); end
      tick();
    end
  endtask

  task automatic test_abort;
    bit seen_done;
    int n;
    dividend = 32'd1000;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    n = 1;
    while (n < 10) begin tick(); n++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    if (hi !== 32'd0)  begin bad++; $display("FAIL abort_hi got=%h want=0", hi); end
    if (lo !== 32'd0)  begin bad++; $display("FAIL abort_lo got=%h want=0", lo); end
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    total += 1;
    if (seen_done) begin bad++; $display("FAIL abort_no_done got=activity want=idle"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_divzero();
    test_interference();
    test_back_to_back();
    test_random();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
